// File: rtl/hs32_pkg.sv
// Shared constants for the hs32 memory arbiter: FSM state encodings and port-select codes.
package hs32_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_F = 2'd1;
    localparam logic [1:0] ARB_BUSY_E = 2'd2;
    localparam logic [1:0] ARB_RESP   = 2'd3;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_EXEC  = 1'b1;

endpackage

// File: rtl/hs32_arb_select.sv
// Priority selector between fetch and execute requests.
// HS32_ARB_RR_EN adds a toggling priority pointer; otherwise execute always wins.
module hs32_arb_select
    import hs32_pkg::*;
(
`ifdef HS32_ARB_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic grant_en,
    input  logic f_req,
    input  logic e_req,
    output logic gnt_valid,
    output logic gnt_sel
);

    assign gnt_valid = grant_en && (f_req || e_req);

`ifdef HS32_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= SEL_EXEC;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only matters when both ports compete.
    assign gnt_sel = (f_req && e_req) ? ptr_q : (e_req ? SEL_EXEC : SEL_FETCH);
`else
    assign gnt_sel = e_req ? SEL_EXEC : SEL_FETCH;
`endif

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Two-initiator (fetch/execute) memory arbiter: one transaction at a time onto an SRAM-style bus.
// Optional macro HS32_ARB_RR_EN selects round-robin instead of execute-first priority.
module hs32_mem_arbiter
    import hs32_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] f_addr,
    input  logic          f_req,
    output logic [DW-1:0] f_dtr,
    output logic          f_rdy,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_dtw,
    input  logic          e_rw,
    input  logic          e_req,
    output logic [DW-1:0] e_dtr,
    output logic          e_rdy,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_dtw,
    output logic          m_rw,
    output logic          m_val,
    input  logic [DW-1:0] m_dtr,
    input  logic          m_rdy
);

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_dtw_q, m_dtw_d;
    logic          m_rw_q, m_rw_d;
    logic          m_val_q, m_val_d;
    logic [DW-1:0] f_dtr_q, f_dtr_d;
    logic [DW-1:0] e_dtr_q, e_dtr_d;
    logic          gnt_valid;
    logic          gnt_sel;

    hs32_arb_select u_select (
`ifdef HS32_ARB_RR_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .grant_en  (state_q == ARB_IDLE),
        .f_req     (f_req),
        .e_req     (e_req),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        m_addr_d = m_addr_q;
        m_dtw_d  = m_dtw_q;
        m_rw_d   = m_rw_q;
        m_val_d  = m_val_q;
        f_dtr_d  = f_dtr_q;
        e_dtr_d  = e_dtr_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    sel_d   = gnt_sel;
                    m_val_d = 1'b1;
                    if (gnt_sel == SEL_EXEC) begin
                        m_addr_d = e_addr;
                        m_dtw_d  = e_dtw;
                        m_rw_d   = e_rw;
                        state_d  = ARB_BUSY_E;
                    end else begin
                        m_addr_d = f_addr;
                        m_rw_d   = 1'b0;
                        state_d  = ARB_BUSY_F;
                    end
                end
            end
            ARB_BUSY_F, ARB_BUSY_E: begin
                if (m_rdy) begin
                    m_val_d = 1'b0;
                    state_d = ARB_RESP;
                    if (!m_rw_q) begin
                        if (state_q == ARB_BUSY_E) begin
                            e_dtr_d = m_dtr;
                        end else begin
                            f_dtr_d = m_dtr;
                        end
                    end
                end
            end
            default: begin
                // Never re-arbitrate here: the initiator moves its address on this edge.
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            sel_q    <= SEL_EXEC;
            m_addr_q <= '0;
            m_dtw_q  <= '0;
            m_rw_q   <= 1'b0;
            m_val_q  <= 1'b0;
            f_dtr_q  <= '0;
            e_dtr_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            m_addr_q <= m_addr_d;
            m_dtw_q  <= m_dtw_d;
            m_rw_q   <= m_rw_d;
            m_val_q  <= m_val_d;
            f_dtr_q  <= f_dtr_d;
            e_dtr_q  <= e_dtr_d;
        end
    end

    // A withdrawn request in RESP suppresses the pulse; the data was still captured.
    assign f_rdy  = (state_q == ARB_RESP) && (sel_q == SEL_FETCH) && f_req;
    assign e_rdy  = (state_q == ARB_RESP) && (sel_q == SEL_EXEC) && e_req;
    assign f_dtr  = f_dtr_q;
    assign e_dtr  = e_dtr_q;
    assign m_addr = m_addr_q;
    assign m_dtw  = m_dtw_q;
    assign m_rw   = m_rw_q;
    assign m_val  = m_val_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Self-checking bench for hs32_mem_arbiter: vector table, hand-written corner sequences, random traffic.
module tb_hs32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] f_addr = '0;
    logic        f_req = 1'b0;
    logic [31:0] f_dtr;
    logic        f_rdy;
    logic [31:0] e_addr = '0;
    logic [31:0] e_dtw = '0;
    logic        e_rw = 1'b0;
    logic        e_req = 1'b0;
    logic [31:0] e_dtr;
    logic        e_rdy;
    logic [31:0] m_addr;
    logic [31:0] m_dtw;
    logic        m_rw;
    logic        m_val;
    logic [31:0] m_dtr = '0;
    logic        m_rdy = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_fdtr;
    logic [31:0] model_edtr;

    hs32_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .f_addr(f_addr), .f_req(f_req), .f_dtr(f_dtr), .f_rdy(f_rdy),
        .e_addr(e_addr), .e_dtw(e_dtw), .e_rw(e_rw), .e_req(e_req),
        .e_dtr(e_dtr), .e_rdy(e_rdy),
        .m_addr(m_addr), .m_dtw(m_dtw), .m_rw(m_rw), .m_val(m_val),
        .m_dtr(m_dtr), .m_rdy(m_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          exec;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          n;
        logic [31:0] exp_dtr;
    } vec_t;

    vec_t vt[6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (f_rdy && e_rdy) begin
            tests++;
            fails++;
            $display("FAIL rdy_excl: f_rdy=%b e_rdy=%b both high", f_rdy, e_rdy);
        end
    end

    // One complete single-initiator transaction; starts and ends in IDLE, #1 after an edge.
    task automatic run_txn(input string tag, input bit exec, input bit rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int n,
                           input logic [31:0] exp_dtr);
        if (exec) begin
            e_req = 1'b1; e_addr = addr; e_dtw = wdata; e_rw = rw;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        cyc();
        for (int k = 1; k <= n; k++) begin
            chk({tag, "_mval"}, {31'd0, m_val}, 32'd1);
            chk({tag, "_maddr"}, m_addr, addr);
            chk({tag, "_mrw"}, {31'd0, m_rw}, {31'd0, exec & rw});
            if (exec) chk({tag, "_mdtw"}, m_dtw, wdata);
            chk({tag, "_early_rdy"}, {30'd0, f_rdy, e_rdy}, 32'd0);
            m_rdy = (k == n);
            m_dtr = rdata;
            cyc();
        end
        m_rdy = 1'b0;
        m_dtr = $urandom;
        chk({tag, "_resp_mval"}, {31'd0, m_val}, 32'd0);
        chk({tag, "_rdy"}, {30'd0, f_rdy, e_rdy}, exec ? 32'd1 : 32'd2);
        chk({tag, "_dtr"}, exec ? e_dtr : f_dtr, exp_dtr);
        $display("[TB] txn %s port=%s rw=%0d addr=%h n=%0d dtr=%h", tag, exec ? "E" : "F", rw,
                 addr, n, exec ? e_dtr : f_dtr);
        f_req = 1'b0;
        e_req = 1'b0;
        cyc();
        chk({tag, "_post_rdy"}, {30'd0, f_rdy, e_rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2,  32'hDEADBEEF};
        vt[1] = '{1, 1, 32'h20,  32'h12345678, 32'hBAD0BAD0, 1,  32'h0};
        vt[2] = '{1, 0, 32'h40,  32'h0,        32'hCAFEF00D, 1,  32'hCAFEF00D};
        vt[3] = '{1, 1, 32'h44,  32'h55AA55AA, 32'h11111111, 3,  32'hCAFEF00D};
        vt[4] = '{0, 0, 32'h104, 32'h0,        32'h0BADF00D, 20, 32'h0BADF00D};
        vt[5] = '{0, 0, 32'h108, 32'h0,        32'h13579BDF, 1,  32'h13579BDF};

        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_outs", {28'd0, f_rdy, e_rdy, m_val, m_rw}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mdtw", m_dtw, 32'd0);
        chk("rst_fdtr", f_dtr, 32'd0);
        chk("rst_edtr", e_dtr, 32'd0);

        // Contention from reset: both ports keep requesting.
        f_addr = 32'h1000; e_addr = 32'h2000; e_rw = 1'b1; e_dtw = 32'h77;
        f_req = 1'b1; e_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit exp_e;
`ifdef HS32_ARB_RR_EN
            exp_e = (i % 2 == 0);
`else
            exp_e = 1'b1;
`endif
            for (int w = 0; w < 4 && !m_val; w++) cyc();
            chk("cont_mval", {31'd0, m_val}, 32'd1);
            chk("cont_winner", m_addr, exp_e ? 32'h2000 : 32'h1000);
            m_rdy = 1'b1; m_dtr = 32'hC0C00000 + i;
            cyc();
            m_rdy = 1'b0;
            chk("cont_rdy", {30'd0, f_rdy, e_rdy}, exp_e ? 32'd1 : 32'd2);
            $display("[TB] contention grant %0d -> %s", i, e_rdy ? "E" : "F");
            if (i == 3) begin
                f_req = 1'b0; e_req = 1'b0;
            end
            cyc();
        end
        e_rw = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].exec, vt[i].rw, vt[i].addr, vt[i].wdata,
                    vt[i].rdata, vt[i].n, vt[i].exp_dtr);
        end
        model_fdtr = 32'h13579BDF;
        model_edtr = 32'hCAFEF00D;

        // Pipeline flush: address moves during BUSY_F with f_req held.
        f_req = 1'b1; f_addr = 32'h200;
        cyc();
        chk("flush_maddr0", m_addr, 32'h200);
        f_addr = 32'h400;
        cyc();
        chk("flush_maddr1", m_addr, 32'h200);
        m_rdy = 1'b1; m_dtr = 32'hF1F10200;
        cyc();
        m_rdy = 1'b0;
        chk("flush_rdy", {30'd0, f_rdy, e_rdy}, 32'd2);
        chk("flush_dtr", f_dtr, 32'hF1F10200);
        $display("[TB] flush first completion dtr=%h", f_dtr);
        cyc();
        cyc();
        chk("flush_newaddr", m_addr, 32'h400);
        m_rdy = 1'b1; m_dtr = 32'hF1F10400;
        cyc();
        m_rdy = 1'b0;
        chk("flush_rdy2", {30'd0, f_rdy, e_rdy}, 32'd2);
        chk("flush_dtr2", f_dtr, 32'hF1F10400);
        f_req = 1'b0;
        cyc();
        model_fdtr = 32'hF1F10400;

        // Dropped request: e_req withdrawn during BUSY_E.
        e_req = 1'b1; e_rw = 1'b0; e_addr = 32'h300;
        cyc();
        e_req = 1'b0;
        m_rdy = 1'b1; m_dtr = 32'hD0D0D0D0;
        cyc();
        m_rdy = 1'b0;
        chk("drop_rdy", {30'd0, f_rdy, e_rdy}, 32'd0);
        chk("drop_dtr", e_dtr, 32'hD0D0D0D0);
        $display("[TB] dropped request, captured e_dtr=%h", e_dtr);
        cyc();
        chk("drop_idle", {30'd0, m_val, e_rdy}, 32'd0);
        model_edtr = 32'hD0D0D0D0;

        for (int i = 0; i < 30; i++) begin
            bit          ex;
            bit          rw;
            logic [31:0] rd;
            logic [31:0] ex_dtr;
            ex = $urandom_range(0, 1) == 1;
            rw = ex ? ($urandom_range(0, 1) == 1) : 1'b0;
            rd = $urandom;
            if (ex) ex_dtr = rw ? model_edtr : rd;
            else    ex_dtr = rd;
            run_txn($sformatf("rnd%0d", i), ex, rw, $urandom, $urandom, rd,
                    $urandom_range(1, 4), ex_dtr);
            if (!rw) begin
                if (ex) model_edtr = rd;
                else    model_fdtr = rd;
            end
        end

        // Reset while BUSY_E, then a late m_rdy that must be ignored.
        e_req = 1'b1; e_rw = 1'b0; e_addr = 32'h80;
        cyc();
        chk("rstmid_mval_before", {31'd0, m_val}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        e_req = 1'b0;
        chk("rstmid_mval", {31'd0, m_val}, 32'd0);
        chk("rstmid_erdy", {31'd0, e_rdy}, 32'd0);
        chk("rstmid_maddr", m_addr, 32'd0);
        m_rdy = 1'b1; m_dtr = 32'hFFFF0000;
        cyc();
        m_rdy = 1'b0;
        chk("spur_mval", {31'd0, m_val}, 32'd0);
        chk("spur_rdy", {30'd0, f_rdy, e_rdy}, 32'd0);
        cyc();
        chk("spur_rdy2", {30'd0, f_rdy, e_rdy}, 32'd0);
        chk("spur_edtr", e_dtr, 32'd0);
        chk("spur_fdtr", f_dtr, 32'd0);
        $display("[TB] reset mid-transaction handled, m_val=%b", m_val);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hs32_mem_arbiter.md
Name: hs32_mem_arbiter

Overview:
- Memory-side responder for the CPU's memory request/ready handshake.
- Serves two initiators: the instruction-fetch port (read-only) and the execute/load-store port (read/write).
- Forwards one transaction at a time to a single external SRAM-style bus, then returns data with a one-cycle ready pulse to the winning initiator.
- Sits between the CPU core and the memory/bus controller.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- f_addr  in  AW  fetch address; meaningful while f_req is high.
- f_req  in  1  fetch request valid.
- f_dtr  out  DW  fetch read data; valid only while f_rdy is high.
- f_rdy  out  1  one-cycle fetch completion pulse.
- e_addr  in  AW  execute address.
- e_dtw  in  DW  execute write data.
- e_rw  in  1  1 = write, 0 = read.
- e_req  in  1  execute request valid.
- e_dtr  out  DW  execute read data; valid while e_rdy is high.
- e_rdy  out  1  one-cycle execute completion pulse.
- m_addr  out  AW  memory address.
- m_dtw  out  DW  memory write data.
- m_rw  out  1  memory write enable.
- m_val  out  1  memory request valid.
- m_dtr  in  DW  memory read data; valid with m_rdy.
- m_rdy  in  1  memory completion, one cycle.

Behaviour:
- Clocking/reset: single clock domain; reset is synchronous and active-high.
- Reset state:
  - State = IDLE.
  - f_rdy, e_rdy, m_val and m_rw are 0.
  - m_addr, m_dtw, f_dtr and e_dtr are 0.
  - Priority pointer = EXEC.
- State machine: IDLE, BUSY_F, BUSY_E, RESP.
- IDLE:
  - If e_req is high, the execute port wins (fixed priority; see optional feature). Else if f_req is high, the fetch port wins.
  - On the grant edge, latch the winner's address into m_addr; for execute also latch e_dtw and e_rw into m_dtw and m_rw (fetch forces m_rw = 0).
  - Go to BUSY_F or BUSY_E. m_val rises in the cycle after the request is seen.
- BUSY_x:
  - Hold m_val = 1 and m_addr/m_dtw/m_rw stable until m_rdy.
  - On m_rdy: capture m_dtr into the winner's dtr register (writes capture nothing and leave dtr unchanged); drop m_val at the same edge; go to RESP.
- RESP:
  - Pulse the winner's rdy for exactly one cycle.
  - The winner's dtr stays held until that port's next completion.
  - Go to IDLE. No arbitration takes place in RESP, because the initiator updates its address at this edge.
- Latency: from the request being seen in IDLE to the rdy pulse is 2 + N cycles, where N is the number of BUSY cycles up to and including m_rdy (minimum N = 1, so minimum latency 3).
- Address latching: the address is captured at grant. If f_addr changes while f_req stays high during BUSY_F (pipeline flush), the transaction completes at the old address and f_rdy still pulses. The initiator is responsible for discarding that stale data.
- Dropped request: if the granted initiator's req is low in RESP, the rdy pulse is suppressed and the data is still captured. The memory transaction is never aborted.
- f_rdy and e_rdy are never high in the same cycle.
- m_val is never high in IDLE or RESP.
- Reset mid-transaction returns to IDLE immediately and m_val drops. The memory controller must tolerate the withdrawn request.
- A spurious m_rdy in IDLE or RESP is ignored.

Optional Feature:
- Macro: HS32_ARB_RR_EN.
- Defined:
  - A 1-bit priority pointer flips to the other port after each grant (flipped at the grant edge).
  - When both requests are high in IDLE, the pointed-to port wins.
  - Prevents back-to-back load/store streams from starving fetch.
- Undefined: fixed execute-over-fetch priority, and the pointer logic is absent.

Decomposition:
- Shared package hs32_pkg holds:
  - state encodings ARB_IDLE, ARB_BUSY_F, ARB_BUSY_E, ARB_RESP;
  - the port-select constants SEL_FETCH and SEL_EXEC.
- One natural sub-module, hs32_arb_select: the combinational/registered priority selector (including the optional round-robin pointer), returning grant-valid and port-select.

Test Plan:
- Fetch read: f_req=1, f_addr=0x100; memory returns 0xDEADBEEF with m_rdy on the 2nd BUSY cycle -> m_addr=0x100, m_rw=0; f_rdy pulses one cycle at cycle 4 after request; f_dtr=0xDEADBEEF; e_rdy stays 0.
- Execute write: e_req=1, e_rw=1, e_addr=0x20, e_dtw=0x12345678; m_rdy after 1 cycle -> m_rw=1, m_dtw=0x12345678 held stable until m_rdy; e_rdy pulses once; e_dtr unchanged.
- Contention: e_req and f_req both high from reset, each re-requesting after completion ->
  - without HS32_ARB_RR_EN: execute granted every time while e_req stays high;
  - with it: grants alternate E, F, E, F.
- Flush mid-fetch: f_addr changes 0x200 to 0x400 during BUSY_F with f_req held -> m_addr stays 0x200; f_rdy pulses with the 0x200 data; the next grant uses 0x400.
- Reset in BUSY_E with m_val=1 -> next cycle m_val=0, state IDLE, no e_rdy; a later m_rdy is ignored.
- Stalled memory: m_rdy withheld for 20 cycles -> m_val, m_addr, m_dtw and m_rw stable for all 20 cycles; exactly one rdy pulse afterward.
